// File: rtl/rvfi_trace_fifo.sv
// RVFI retirement trace buffer: captures one record per retired instruction into a
// DEPTH-entry FIFO and streams each record out as eight 32-bit words.
module rvfi_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     rvfi_valid,
    input  logic [63:0]              rvfi_order,
    input  logic [31:0]              rvfi_insn,
    input  logic                     rvfi_trap,
    input  logic                     rvfi_halt,
    input  logic                     rvfi_intr,
    input  logic [4:0]               rvfi_rd_addr,
    input  logic [31:0]              rvfi_rd_wdata,
    input  logic [31:0]              rvfi_pc_rdata,
    input  logic [31:0]              rvfi_pc_wdata,
    input  logic [31:0]              rvfi_mem_addr,
    input  logic [3:0]               rvfi_mem_rmask,
    input  logic [3:0]               rvfi_mem_wmask,
    input  logic [31:0]              rvfi_mem_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    input  logic                     drop_clr,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef logic [7:0][31:0] rec_t;

    rec_t          mem [DEPTH];
    rec_t          new_rec;
    rec_t          head_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [2:0]    word_idx, idx_nxt;
    logic [AW:0]   level_nxt;
    logic [31:0]   data_nxt;
    logic          last_nxt;
    logic          push_req, hs, pop, accept, drop;

    always_comb begin
        new_rec[0] = rvfi_order[31:0];
        new_rec[1] = rvfi_insn;
        new_rec[2] = rvfi_pc_rdata;
        new_rec[3] = rvfi_pc_wdata;
        new_rec[4] = rvfi_rd_wdata;
        new_rec[5] = rvfi_mem_addr;
        new_rec[6] = {rvfi_order[47:32], rvfi_intr, rvfi_halt, rvfi_trap,
                      rvfi_mem_rmask, rvfi_mem_wmask, rvfi_rd_addr};
        new_rec[7] = rvfi_mem_wdata;
    end

    assign out_valid = (level != '0);
    assign hs        = out_valid & out_ready;
    assign pop       = hs & out_last;
    assign push_req  = rvfi_valid & en;
    // A full FIFO still takes a record when the head frees on the same edge.
    assign accept    = push_req & ((level != LVL_FULL) | pop);
    assign drop      = push_req & ~accept;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        level_nxt  = level;
        rd_ptr_nxt = rd_ptr;
        idx_nxt    = word_idx;
        if (accept && !pop) begin
            level_nxt = level + LVL_ONE;
        end else if (!accept && pop) begin
            level_nxt = level - LVL_ONE;
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        if (hs) begin
            idx_nxt = word_idx + 3'd1;
        end
        // The sole entry after this edge is the record being written now.
        if (accept && level_nxt == LVL_ONE) begin
            head_nxt = new_rec;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
        data_nxt = (level_nxt != '0) ? head_nxt[idx_nxt] : 32'h0;
        last_nxt = (level_nxt != '0) && (idx_nxt == 3'd7);
    end

    // NOTE: record storage carries no reset; level and pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            level    <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr   <= rd_ptr_nxt;
            word_idx <= idx_nxt;
            level    <= level_nxt;
            out_data <= data_nxt;
            out_last <= last_nxt;
        end
    end

    // Clear wins over a same-cycle drop; the counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop_clr) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_ONE;
            end
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Scoreboard bench for rvfi_trace_fifo: a cycle model predicts level, drops and
// the word stream; every presented word is checked against the queue head.
module tb_rvfi_trace_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_halt = 1'b0;
    logic        rvfi_intr = 1'b0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic [31:0] rvfi_pc_wdata = '0;
    logic [31:0] rvfi_mem_addr = '0;
    logic [3:0]  rvfi_mem_rmask = '0;
    logic [3:0]  rvfi_mem_wmask = '0;
    logic [31:0] rvfi_mem_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        drop_clr = 1'b0;
    logic [CNT_W-1:0] drop_count;
    logic        overflow;
    logic [$clog2(DEPTH):0] level;

    rvfi_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_wdata(rvfi_mem_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .drop_clr(drop_clr),
        .drop_count(drop_count), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } sb_t;

    sb_t             q[$];
    int              m_level = 0;
    logic [CNT_W-1:0] m_drop = '0;
    logic            m_ovf = 1'b0;
    int              total = 0;
    int              bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rec_word(input int i);
        case (i)
            0: return rvfi_order[31:0];
            1: return rvfi_insn;
            2: return rvfi_pc_rdata;
            3: return rvfi_pc_wdata;
            4: return rvfi_rd_wdata;
            5: return rvfi_mem_addr;
            6: return {rvfi_order[47:32], rvfi_intr, rvfi_halt, rvfi_trap,
                       rvfi_mem_rmask, rvfi_mem_wmask, rvfi_rd_addr};
            default: return rvfi_mem_wdata;
        endcase
    endfunction

    // Sample 2 time units after the falling edge: outputs settled, inputs set.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            q.delete();
            m_level = 0;
            m_drop  = '0;
            m_ovf   = 1'b0;
        end else begin
            bit hs, pop_rec, push, accept;
            check("level", level, m_level);
            check("out_valid", out_valid, m_level != 0);
            check("drop_count", drop_count, m_drop);
            check("overflow", overflow, m_ovf);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("sb_empty_while_valid", 1, 0);
                end else begin
                    check("out_data", out_data, q[0].data);
                    check("out_last", out_last, q[0].last);
                end
            end
            hs      = out_valid && out_ready;
            pop_rec = hs && (q.size() > 0) && q[0].last;
            if (hs && q.size() > 0) void'(q.pop_front());
            push    = rvfi_valid && en;
            accept  = push && (m_level < DEPTH || pop_rec);
            if (accept) begin
                for (int i = 0; i < 8; i++) begin
                    sb_t e;
                    e.data = rec_word(i);
                    e.last = (i == 7);
                    q.push_back(e);
                end
            end
            m_level = m_level + int'(accept) - int'(pop_rec);
            if (drop_clr) begin
                m_drop = '0;
                m_ovf  = 1'b0;
            end else if (push && !accept) begin
                if (m_drop != '1) m_drop = m_drop + 1'b1;
                m_ovf = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] ord);
        rvfi_valid     = 1'b1;
        en             = 1'b1;
        rvfi_order     = {$urandom(), ord};
        rvfi_insn      = $urandom();
        rvfi_trap      = 1'($urandom_range(1));
        rvfi_halt      = 1'($urandom_range(1));
        rvfi_intr      = 1'($urandom_range(1));
        rvfi_rd_addr   = 5'($urandom_range(31));
        rvfi_rd_wdata  = $urandom();
        rvfi_pc_rdata  = $urandom();
        rvfi_pc_wdata  = $urandom();
        rvfi_mem_addr  = $urandom();
        rvfi_mem_rmask = 4'($urandom_range(15));
        rvfi_mem_wmask = 4'($urandom_range(15));
        rvfi_mem_wdata = $urandom();
    endtask

    task automatic set_simple();
        rvfi_valid = 1'b1; en = 1'b1;
        rvfi_order = 64'd5; rvfi_insn = 32'h0050_0093;
        rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_intr = 1'b0;
        rvfi_rd_addr = 5'd1; rvfi_rd_wdata = 32'd5;
        rvfi_pc_rdata = 32'h100; rvfi_pc_wdata = 32'h104;
        rvfi_mem_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0; rvfi_mem_wdata = '0;
    endtask

    task automatic drain(input bit bp);
        logic [3:0] pat = 4'b1001;
        int n = 0;
        rvfi_valid = 1'b0;
        while ((q.size() != 0 || m_level != 0) && n < 600) begin
            out_ready = bp ? pat[n % 4] : 1'b1;
            n++;
            cyc();
        end
        check("drain_done", q.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        bit found;
        cyc();
        cyc();
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_drops", drop_count, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        cyc();

        // Single retirement, plus an ignored strobe with en low.
        set_simple();
        cyc();
        rvfi_valid = 1'b1; en = 1'b0;
        cyc();
        rvfi_valid = 1'b0; en = 1'b1;
        check("t1_level_one", level, 1);
        check("t1_word0", out_data, 5);
        drain(1'b0);
        check("t1_level_zero", level, 0);

        // Backpressure with en dropped during draining.
        set_simple();
        cyc();
        rvfi_valid = 1'b0; en = 1'b0;
        drain(1'b1);
        en = 1'b1;

        // Overflow: ten retirements into a stalled FIFO.
        for (int i = 0; i < 10; i++) begin
            set_rec(i);
            cyc();
        end
        rvfi_valid = 1'b0;
        check("t3_level", level, 8);
        check("t3_drops", drop_count, 2);
        check("t3_ovf", overflow, 1);
        drain(1'b0);

        // Full FIFO takes a record on the word-7 handshake.
        for (int i = 0; i < 8; i++) begin
            set_rec(100 + i);
            cyc();
        end
        rvfi_valid = 1'b0;
        out_ready  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (out_valid && out_last) begin
                set_rec(200);
                found = 1'b1;
            end
        end
        check("t4_found_last", found, 1);
        cyc();
        rvfi_valid = 1'b0;
        out_ready  = 1'b0;
        check("t4_level", level, 8);
        check("t4_drops", drop_count, 2);
        drain(1'b0);

        // Saturation, then clear racing a drop.
        for (int i = 0; i < 8; i++) begin
            set_rec(300 + i);
            cyc();
        end
        set_rec(999);
        repeat (65540) cyc();
        rvfi_valid = 1'b0;
        check("t5_sat", drop_count, 16'hFFFF);
        check("t5_sat_ovf", overflow, 1);
        set_rec(998);
        drop_clr = 1'b1;
        cyc();
        rvfi_valid = 1'b0;
        drop_clr   = 1'b0;
        check("t5_clr_drops", drop_count, 0);
        check("t5_clr_ovf", overflow, 0);
        set_rec(997);
        cyc();
        rvfi_valid = 1'b0;
        check("t5_redrop", drop_count, 1);

        // Reset after word 3 of the fifth record.
        out_ready = 1'b1;
        repeat (36) cyc();
        out_ready = 1'b0;
        check("t6_level_pre", level, 4);
        rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_level", level, 0);
        check("t6_drops", drop_count, 0);
        check("t6_ovf", overflow, 0);
        check("t6_last", out_last, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        set_rec(32'h77);
        cyc();
        rvfi_valid = 1'b0;
        check("t6_word0", out_data, 32'h77);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvfi_trace_fifo.md
Name: rvfi_trace_fifo

Overview:
Downstream consumer of the hart's RVFI retirement port, used in simulation and on-chip debug builds. Captures one record per retired instruction into a DEPTH-entry FIFO. Serialises each record as eight 32-bit words on a valid/ready stream for a trace UART or DMA sink. Counts records dropped on overflow.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  capture enable; 0 = ignore rvfi_valid
rvfi_valid  in  1  retirement strobe
rvfi_order  in  64  retirement index
rvfi_insn  in  32  instruction word
rvfi_trap  in  1  trap flag
rvfi_halt  in  1  halt flag
rvfi_intr  in  1  interrupt flag
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
rvfi_pc_rdata  in  32  PC of instruction
rvfi_pc_wdata  in  32  next PC
rvfi_mem_addr  in  32  memory address
rvfi_mem_rmask  in  4  read byte mask
rvfi_mem_wmask  in  4  write byte mask
rvfi_mem_wdata  in  32  memory write data
out_valid  out  1  word available
out_ready  in  1  sink accepts word
out_data  out  32  current word
out_last  out  1  high on word 7 of a record
drop_clr  in  1  synchronous clear of drop_count and overflow
drop_count  out  CNT_W  dropped records, saturating
overflow  out  1  sticky, set on first drop
level  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n low, async): FIFO empty, word index 0, out_valid=0, out_last=0, out_data=0, drop_count=0, overflow=0, level=0.
- Push condition: rvfi_valid & en on a rising edge. The record is written at that edge.
- Full-entry accept: when level==DEPTH, the push is accepted only if the head record is freed on the same edge (out_valid & out_ready & out_last). Otherwise the record is dropped.
- On a drop: drop_count increments, saturating at all-ones; overflow sets.
- drop_clr has priority over a same-cycle drop. Result is drop_count=0, overflow=0.
- Record word layout (word index 0..7):
  - 0: order[31:0]
  - 1: insn
  - 2: pc_rdata
  - 3: pc_wdata
  - 4: rd_wdata
  - 5: mem_addr
  - 6: {order[47:32], intr, halt, trap, mem_rmask, mem_wmask, rd_addr}, packed MSB to LSB. rd_addr occupies [4:0] and intr occupies [15].
  - 7: mem_wdata
  - order[63:48] is discarded.
- Serialiser: out_valid = (level != 0). out_data is the head record selected by word index, registered from FIFO storage. There is no combinational path from rvfi_* to out_*.
- Latency: for a push into an empty FIFO at edge N, out_valid is high in the cycle after edge N with word 0.
- Word advance: on each out_valid & out_ready, the word index advances. At index 7 (out_last=1), the index wraps to 0 and the head pops.
- Backpressure: while out_valid & !out_ready, out_data and out_last hold stable.
- out_valid never deasserts mid-record.
- Simultaneous push and pop: level unchanged. Pointers wrap modulo DEPTH.
- en deassertion mid-record does not affect draining.
- Reset mid-record discards the partial record and all FIFO contents.

Test Plan:
1. Single retirement: order=5, insn=0x00500093, pc 0x100->0x104, rd=1, rd_wdata=5 -> eight words 5, 0x00500093, 0x100, 0x104, 5, 0, 0x00000001, 0. out_last only on word 8. level returns to 0.
2. Backpressure: out_ready toggled 1,0,0,1 throughout a record -> every word delivered exactly once, stable while stalled, same sequence as scenario 1.
3. Overflow: DEPTH=8, out_ready=0, 10 consecutive retirements -> level=8, drop_count=2, overflow=1. Drained records are order 0..7.
4. Full push with pop: level=8, retirement on the same edge as the word-7 handshake -> no drop, level stays 8, the new record is drained last.
5. drop_clr on the same edge as a drop -> drop_count=0, overflow=0. drop_count saturates at 0xFFFF after 65535+ drops.
6. rst_n pulsed low after word 3 of a record with 4 entries queued -> out_valid=0, level=0, drop_count=0 immediately. Next retirement starts at word 0.
